// File: rtl/pdu_lqiterator.sv
// rtl/pdu_lqiterator.sv - walks a logical-qubit bitmask and streams each set index, one per cycle
module pdu_lqiterator #(
    parameter int NUM_LQ    = 8,
    parameter int LQADDR_BW = 3,
    parameter int RR_MODE   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [NUM_LQ-1:0]    load_lqlist,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LQADDR_BW-1:0] out_lqidx,
    output logic                 out_last,
    output logic [LQADDR_BW:0]   remain_cnt,
    output logic                 done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [NUM_LQ-1:0]      r_pend;
    logic [LQADDR_BW-1:0]   r_rr_ptr;
    logic                   r_done;

    state_t                 w_state_nxt;
    logic [NUM_LQ-1:0]      w_pend_nxt;
    logic [LQADDR_BW-1:0]   w_rr_nxt;
    logic                   w_done_nxt;

    logic [LQADDR_BW-1:0]   w_sel_low;
    logic [LQADDR_BW-1:0]   w_sel_rr;
    logic [LQADDR_BW-1:0]   w_sel;
    logic [LQADDR_BW:0]     w_pos_wide;
    logic [LQADDR_BW-1:0]   w_pos;
    logic [LQADDR_BW:0]     w_popcnt;
    logic                   w_last;
    logic                   w_run;

    always_comb begin
        w_sel_low = '0;
        for (int i = NUM_LQ - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel_low = LQADDR_BW'(i);
            end
        end
    end

    // Scan offsets from the top down so the smallest wrapped distance from rr_ptr wins.
    always_comb begin
        w_sel_rr   = '0;
        w_pos_wide = '0;
        w_pos      = '0;
        for (int k = NUM_LQ - 1; k >= 0; k--) begin
            w_pos_wide = {1'b0, r_rr_ptr} + (LQADDR_BW+1)'(k);
            if (w_pos_wide >= (LQADDR_BW+1)'(NUM_LQ)) begin
                w_pos_wide = w_pos_wide - (LQADDR_BW+1)'(NUM_LQ);
            end
            w_pos = w_pos_wide[LQADDR_BW-1:0];
            if (r_pend[w_pos]) begin
                w_sel_rr = w_pos;
            end
        end
    end

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_LQ; i++) begin
            w_popcnt = w_popcnt + {{LQADDR_BW{1'b0}}, r_pend[i]};
        end
    end

    assign w_sel  = (RR_MODE != 0) ? w_sel_rr : w_sel_low;
    assign w_run  = (r_state == ST_RUN);
    assign w_last = w_run && (w_popcnt == (LQADDR_BW+1)'(1));

    assign load_ready = !w_run;
    assign out_valid  = w_run;
    assign out_lqidx  = w_run ? w_sel : '0;
    assign out_last   = w_last;
    assign remain_cnt = w_run ? w_popcnt : '0;
    assign done       = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_rr_nxt    = r_rr_ptr;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!flush && load_valid) begin
                    w_pend_nxt = load_lqlist;
                    if (load_lqlist != '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_pend_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end else if (out_ready) begin
                    w_pend_nxt = r_pend & ~(NUM_LQ'(1) << w_sel);
                    if (RR_MODE != 0) begin
                        w_rr_nxt = (w_sel == LQADDR_BW'(NUM_LQ - 1)) ? '0 : w_sel + 1'b1;
                    end
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pend_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pend   <= '0;
            r_rr_ptr <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pend   <= w_pend_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_done   <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_pdu_lqiterator.sv
// tb/tb_pdu_lqiterator.sv - scoreboard bench for pdu_lqiterator in both selection modes
module tb_pdu_lqiterator;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       load_valid;
    logic [7:0] load_lqlist;
    logic       out_ready;

    logic       load_ready_0, out_valid_0, out_last_0, done_0;
    logic [2:0] out_lqidx_0;
    logic [3:0] remain_cnt_0;
    logic       load_ready_1, out_valid_1, out_last_1, done_1;
    logic [2:0] out_lqidx_1;
    logic [3:0] remain_cnt_1;

    pdu_lqiterator #(.NUM_LQ(8), .LQADDR_BW(3), .RR_MODE(0)) u_low (
        .clk(clk), .rst(rst), .flush(flush),
        .load_valid(load_valid), .load_ready(load_ready_0), .load_lqlist(load_lqlist),
        .out_valid(out_valid_0), .out_ready(out_ready), .out_lqidx(out_lqidx_0),
        .out_last(out_last_0), .remain_cnt(remain_cnt_0), .done(done_0)
    );

    pdu_lqiterator #(.NUM_LQ(8), .LQADDR_BW(3), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .flush(flush),
        .load_valid(load_valid), .load_ready(load_ready_1), .load_lqlist(load_lqlist),
        .out_valid(out_valid_1), .out_ready(out_ready), .out_lqidx(out_lqidx_1),
        .out_last(out_last_1), .remain_cnt(remain_cnt_1), .done(done_1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int last;
        int rem;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   rr_m = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic int popcount8(input logic [7:0] m);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m[i]);
        return c;
    endfunction

    function automatic void push_expected(input logic [7:0] m);
        int   rem;
        exp_t e;
        rem = popcount8(m);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                e.idx = i; e.rem = rem; e.last = (rem == 1); rem--;
                q0.push_back(e);
            end
        end
        rem = popcount8(m);
        for (int k = 0; k < 8; k++) begin
            int p;
            p = (rr_m + k) % 8;
            if (m[p]) begin
                e.idx = p; e.rem = rem; e.last = (rem == 1); rem--;
                q1.push_back(e);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && !flush && out_ready) begin
            if (out_valid_0) begin
                if (q0.size() == 0) begin
                    check_eq("low_unexpected_out", q0.size(), 1);
                end else begin
                    e0 = q0.pop_front();
                    check_eq("low_idx", out_lqidx_0, e0.idx);
                    check_eq("low_last", out_last_0, e0.last);
                    check_eq("low_remain", remain_cnt_0, e0.rem);
                end
            end
            if (out_valid_1) begin
                if (q1.size() == 0) begin
                    check_eq("rr_unexpected_out", q1.size(), 1);
                end else begin
                    e1 = q1.pop_front();
                    check_eq("rr_idx", out_lqidx_1, e1.idx);
                    check_eq("rr_last", out_last_1, e1.last);
                    check_eq("rr_remain", remain_cnt_1, e1.rem);
                    rr_m = (e1.idx + 1) % 8;
                end
            end
        end
    end

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready0"}, load_ready_0, 1);
        check_eq({tag, "_valid0"}, out_valid_0, 0);
        check_eq({tag, "_idx0"}, out_lqidx_0, 0);
        check_eq({tag, "_last0"}, out_last_0, 0);
        check_eq({tag, "_rem0"}, remain_cnt_0, 0);
        check_eq({tag, "_ready1"}, load_ready_1, 1);
        check_eq({tag, "_valid1"}, out_valid_1, 0);
        check_eq({tag, "_idx1"}, out_lqidx_1, 0);
        check_eq({tag, "_rem1"}, remain_cnt_1, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        q1.delete();
        rr_m = 0;
    endtask

    task automatic load_list(input logic [7:0] m);
        load_valid  = 1'b1;
        load_lqlist = m;
        @(posedge clk);
        push_expected(m);
        #1 load_valid = 1'b0;
        load_lqlist = 8'h00;
    endtask

    // The k-th negedge after the accept edge lies in cycle t+k; done belongs to cycle t+pop+1.
    task automatic finish_list(input string tag, input int pop);
        for (int k = 1; k <= pop + 1; k++) begin
            @(negedge clk);
            if (k <= pop) begin
                check_eq({tag, "_valid_run"}, out_valid_0, 1);
                check_eq({tag, "_nodone"}, done_0, 0);
                check_eq({tag, "_ready_run"}, load_ready_1, 0);
            end else begin
                check_eq({tag, "_done0"}, done_0, 1);
                check_eq({tag, "_done1"}, done_1, 1);
                check_idle(tag);
            end
        end
        @(negedge clk);
        check_eq({tag, "_done_once0"}, done_0, 0);
        check_eq({tag, "_done_once1"}, done_1, 0);
        check_eq({tag, "_q0_drained"}, q0.size(), 0);
        check_eq({tag, "_q1_drained"}, q1.size(), 0);
    endtask

    task automatic run_list(input string tag, input logic [7:0] m);
        load_list(m);
        finish_list(tag, popcount8(m));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; load_valid = 1'b0; load_lqlist = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check_eq("reset_done0", done_0, 0);
        check_eq("reset_done1", done_1, 0);

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        run_list("basic_a4", 8'b1010_0100);

        do_reset();
        run_list("rr_81", 8'b1000_0001);
        run_list("rr_05", 8'b0000_0101);
        run_list("rr_03", 8'b0000_0011);

        @(posedge clk);
        #1 out_ready = 1'b0;
        load_list(8'b0001_0010);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("bp_idx0", out_lqidx_0, q0[0].idx);
            check_eq("bp_rem0", remain_cnt_0, 2);
            check_eq("bp_idx1", out_lqidx_1, q1[0].idx);
            check_eq("bp_rem1", remain_cnt_1, 2);
            check_eq("bp_valid", out_valid_1, 1);
            check_eq("bp_nodone", done_0, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        finish_list("bp", 2);

        @(posedge clk);
        #1;
        load_list(8'h00);
        @(negedge clk);
        check_eq("empty_done0", done_0, 1);
        check_eq("empty_done1", done_1, 1);
        check_idle("empty");
        @(negedge clk);
        check_eq("empty_done_once", done_0, 0);
        check_eq("empty_ready", load_ready_0, 1);

        @(posedge clk);
        #1;
        load_list(8'b1111_0000);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_idle("flush");
            check_eq("flush_nodone0", done_0, 0);
            check_eq("flush_nodone1", done_1, 0);
        end
        run_list("post_flush", 8'b0000_1000);

        @(posedge clk);
        #1;
        load_list(8'b0000_1111);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        q1.delete();
        rr_m = 0;
        @(negedge clk);
        check_idle("midrst");
        check_eq("midrst_done0", done_0, 0);
        check_eq("midrst_done1", done_1, 0);
        run_list("post_rst", 8'b0000_0011);

        for (int n = 0; n < 6; n++) begin
            logic [7:0] m;
            m = 8'($urandom_range(1, 255));
            run_list("rand", m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
